// File: rtl/conv_pkg.sv
// conv_pkg -- definitions shared by the activation streamer blocks.
//   MatrixSizeBits   : width of the unpadded matrix side input
//   PaddingBits      : width of the border width input
//   streamer_state_t : streamer FSM state encoding
package conv_pkg;

  localparam int MatrixSizeBits = 14;
  localparam int PaddingBits    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } streamer_state_t;

endpackage

// File: rtl/activation_streamer_if.sv
// activation_streamer_if -- activation memory read port.
//   mem_rd_en_o : read strobe from the streamer
//   mem_addr_o  : read address, meaningful while mem_rd_en_o is high
//   mem_data_i  : read data back to the streamer
// Handshake: there is no ready. The memory always accepts a strobe, and the
// data for a strobe in cycle t is valid on mem_data_i in cycle t+1 only.
// Modports: master = streamer side, slave = memory side.
interface activation_streamer_if #(
  parameter int N        = 16,
  parameter int AddrBits = 28
);
  logic                mem_rd_en_o;
  logic [AddrBits-1:0] mem_addr_o;
  logic [N-1:0]        mem_data_i;

  modport master (output mem_rd_en_o, output mem_addr_o, input mem_data_i);
  modport slave  (input mem_rd_en_o, input mem_addr_o, output mem_data_i);
endinterface

// File: rtl/skid_register.sv
// skid_register -- one-entry holding register for the output beat.
//   clk, rst  : clock, asynchronous active-high reset
//   hold      : consumer pause; nothing leaves while high
//   in_valid  : beat arriving from the one-cycle stage
//   in_data   : that beat's data
//   out_valid : beat presented this cycle
//   out_data  : data of the presented beat
// The streamer stops issuing while hold is high, so at most one beat is ever
// in flight when a pause starts; one entry is therefore enough.
module skid_register #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic         full;
  logic [W-1:0] held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      held <= '0;
    end else if (hold) begin
      // Capture the in-flight beat; memory data is only valid for one cycle.
      if (in_valid) begin
        full <= 1'b1;
        held <= in_data;
      end
    end else begin
      full <= 1'b0;
    end
  end

  // When full and released, no new beat can arrive in the same cycle.
  assign out_valid = !hold && (full || in_valid);
  assign out_data  = full ? held : in_data;
endmodule

// File: rtl/activation_streamer.sv
// activation_streamer -- streams one square activation matrix, row-major,
// optionally surrounded by a border of constant fill elements.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   start_i       : request one matrix (accepted in IDLE only)
//   matrix_size_i : unpadded side M;  padding_i : border width P
//   pad_fill_i    : border element value;  base_addr_i : address of (0,0)
//   hold_i        : consumer pause
//   mem           : activation memory read port (master)
//   data_o/valid_o: streamed beat;  busy_o : stream in progress
//   done_o        : one-cycle pulse after the final beat
//   dbg_state     : current FSM state
// Build option: define STREAMER_PADDING_EN to enable the border; otherwise
// padding_i and pad_fill_i are ignored and P is taken as 0.
module activation_streamer
  import conv_pkg::*;
#(
  parameter int MaxMatrixSize = 16383,
  parameter int N             = 16,
  parameter int AddrBits      = 28
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [MatrixSizeBits-1:0] matrix_size_i,
  input  logic [PaddingBits-1:0]    padding_i,
  input  logic [N-1:0]              pad_fill_i,
  input  logic [AddrBits-1:0]       base_addr_i,
  input  logic                      hold_i,
  activation_streamer_if.master     mem,
  output logic [N-1:0]              data_o,
  output logic                      valid_o,
  output logic                      busy_o,
  output logic                      done_o,
  output streamer_state_t           dbg_state
);
  // Padded side is M + 2P; for the defaults this is 15 bits.
  localparam int SideBits = $clog2(MaxMatrixSize + 2 * ((1 << PaddingBits) - 1) + 1);

  streamer_state_t           state, state_next;
  logic [MatrixSizeBits-1:0] m_q;
  logic [AddrBits-1:0]       base_q, offset_q;
  logic [SideBits-1:0]       row_q, col_q, side;
  logic                      issue, interior, last_elem, last_int;
  logic                      pipe_v, stage_valid;
  logic [N-1:0]              stage_data, skid_data;

`ifdef STREAMER_PADDING_EN
  logic [PaddingBits-1:0] p_q;
  logic [N-1:0]           fill_q;
  logic                   pipe_border;
  logic [SideBits-1:0]    lo, hi;

  assign side     = SideBits'(m_q) + SideBits'({p_q, 1'b0});
  assign lo       = SideBits'(p_q);
  assign hi       = SideBits'(p_q) + SideBits'(m_q);
  assign interior = (row_q >= lo) && (row_q < hi) && (col_q >= lo) && (col_q < hi);
  assign last_int = (row_q == hi - SideBits'(1)) && (col_q == hi - SideBits'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q         <= '0;
      fill_q      <= '0;
      pipe_border <= 1'b0;
    end else begin
      pipe_border <= !interior;
      if (state == IDLE && start_i) begin
        p_q    <= padding_i;
        fill_q <= pad_fill_i;
      end
    end
  end

  // Border beats ride the same stage as reads so ordering is preserved.
  assign stage_data = pipe_border ? fill_q : mem.mem_data_i;
`else
  logic unused_pad;
  assign unused_pad = ^{padding_i, pad_fill_i};
  assign side       = SideBits'(m_q);
  assign interior   = 1'b1;
  assign last_int   = last_elem;
  assign stage_data = mem.mem_data_i;
`endif

  assign issue     = (state == STREAM) && !hold_i;
  assign last_elem = (row_q == side - SideBits'(1)) && (col_q == side - SideBits'(1));

  assign mem.mem_rd_en_o = issue && interior;
  assign mem.mem_addr_o  = mem.mem_rd_en_o ? base_q + offset_q : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = (matrix_size_i == '0) ? DONE : STREAM;
      STREAM:  if (issue && last_elem) state_next = DRAIN;
      // Issuing has stopped, so the next beat out is the final one.
      DRAIN:   if (valid_o) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      m_q      <= '0;
      base_q   <= '0;
      offset_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      pipe_v   <= 1'b0;
    end else begin
      state  <= state_next;
      pipe_v <= issue;
      if (state == IDLE && start_i) begin
        m_q      <= matrix_size_i;
        base_q   <= base_addr_i;
        offset_q <= '0;
        row_q    <= '0;
        col_q    <= '0;
      end else if (issue) begin
        // Offset returns to 0 after the last interior read instead of
        // stepping past M*M-1.
        if (interior) offset_q <= last_int ? '0 : offset_q + AddrBits'(1);
        if (col_q == side - SideBits'(1)) begin
          col_q <= '0;
          row_q <= last_elem ? '0 : row_q + SideBits'(1);
        end else begin
          col_q <= col_q + SideBits'(1);
        end
      end
    end
  end

  skid_register #(.W(N)) u_skid (
    .clk       (clk_i),
    .rst       (rst_i),
    .hold      (hold_i),
    .in_valid  (pipe_v),
    .in_data   (stage_data),
    .out_valid (stage_valid),
    .out_data  (skid_data)
  );

  assign valid_o   = stage_valid;
  assign data_o    = stage_valid ? skid_data : '0;
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign dbg_state = state;
endmodule

// File: tb/tb_activation_streamer.sv
// tb_activation_streamer -- directed bench for activation_streamer.
// A reactive memory model returns the low N bits of the address one cycle
// after each read strobe (and 16'hDEAD otherwise). Beats, reads and done
// pulses are recorded on the falling edge and checked against hand-built
// expectations in each test task.
module tb_activation_streamer;
  import conv_pkg::*;

  localparam int N        = 16;
  localparam int AddrBits = 28;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                hold = 1'b0;
  logic [13:0]         msize = '0;
  logic [3:0]          pad = '0;
  logic [N-1:0]        fill = '0;
  logic [AddrBits-1:0] base = '0;
  logic [N-1:0]        data;
  logic                valid, busy, done;
  streamer_state_t     dbg_state;

  activation_streamer_if #(.N(N), .AddrBits(AddrBits)) mem ();

  activation_streamer #(.MaxMatrixSize(16383), .N(N), .AddrBits(AddrBits)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .matrix_size_i (msize),
    .padding_i     (pad),
    .pad_fill_i    (fill),
    .base_addr_i   (base),
    .hold_i        (hold),
    .mem           (mem.master),
    .data_o        (data),
    .valid_o       (valid),
    .busy_o        (busy),
    .done_o        (done),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    mem.mem_data_i <= mem.mem_rd_en_o ? N'(mem.mem_addr_o) : N'(16'hDEAD);

  // ---------------- observers / scoreboard ----------------
  int           cyc = 0;
  logic [N-1:0] got_q[$];
  int           got_cyc[$];
  logic [N-1:0] exp_q[$];
  int           reads = 0, dones = 0, done_cyc = 0, hold_beats = 0;
  int           n_checks = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(data);
      got_cyc.push_back(cyc);
      if (hold) hold_beats++;
    end
    if (mem.mem_rd_en_o) reads++;
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    reads = 0;
    dones = 0;
    hold_beats = 0;
  endtask

  task automatic start_stream(input logic [13:0] m, input logic [3:0] p,
                              input logic [N-1:0] f, input logic [AddrBits-1:0] b);
    @(posedge clk); #1;
    msize = m; pad = p; fill = f; base = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (dones > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (mem.mem_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", mem.mem_rd_en_o); end
    n_checks++; if (data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", data); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit           to;
    logic [N-1:0] g;
    clear_obs();
    for (int i = 0; i < 9; i++) exp_q.push_back(N'(i));
    start_stream(14'd3, 4'd0, '0, '0);
    wait_done(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() != 9) begin n_fail++; $display("FAIL basic_count: got %0d expected 9", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL basic_beat[%0d]: got %0h expected %0h", i, g, exp_q[i]); end
    end
    if (got_cyc.size() == 9) begin
      n_checks++; if (got_cyc[8] - got_cyc[0] != 8) begin n_fail++; $display("FAIL basic_consecutive: got span %0d expected 8", got_cyc[8] - got_cyc[0]); end
      n_checks++; if (done_cyc != got_cyc[8] + 1) begin n_fail++; $display("FAIL basic_done_time: got cycle %0d expected %0d", done_cyc, got_cyc[8] + 1); end
    end
    n_checks++; if (reads != 9) begin n_fail++; $display("FAIL basic_reads: got %0d expected 9", reads); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", dones); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_base_offset();
    bit           to;
    logic [N-1:0] g;
    clear_obs();
    for (int i = 0; i < 4; i++) exp_q.push_back(N'(16'h40 + i));
    start_stream(14'd2, 4'd0, '0, 28'h40);
    wait_done(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL base_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL base_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL base_beat[%0d]: got %0h expected %0h", i, g, exp_q[i]); end
    end
    n_checks++; if (reads != 4) begin n_fail++; $display("FAIL base_reads: got %0d expected 4", reads); end
  endtask

`ifdef STREAMER_PADDING_EN
  task automatic test_padding();
    bit           to;
    logic [N-1:0] g;
    logic [N-1:0] pat [16];
    pat = '{16'h7F, 16'h7F, 16'h7F, 16'h7F, 16'h7F, 16'h0, 16'h1, 16'h7F,
            16'h7F, 16'h2, 16'h3, 16'h7F, 16'h7F, 16'h7F, 16'h7F, 16'h7F};
    clear_obs();
    for (int i = 0; i < 16; i++) exp_q.push_back(pat[i]);
    start_stream(14'd2, 4'd1, 16'h7F, '0);
    wait_done(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL pad_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() != 16) begin n_fail++; $display("FAIL pad_count: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL pad_beat[%0d]: got %0h expected %0h", i, g, exp_q[i]); end
    end
    n_checks++; if (reads != 4) begin n_fail++; $display("FAIL pad_reads: got %0d expected 4", reads); end
  endtask
`else
  task automatic test_no_padding();
    bit           to;
    logic [N-1:0] g;
    clear_obs();
    for (int i = 0; i < 4; i++) exp_q.push_back(N'(i));
    start_stream(14'd2, 4'd1, 16'h7F, '0);
    wait_done(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL nopad_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL nopad_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL nopad_beat[%0d]: got %0h expected %0h", i, g, exp_q[i]); end
    end
    n_checks++; if (reads != 4) begin n_fail++; $display("FAIL nopad_reads: got %0d expected 4", reads); end
  endtask
`endif

  task automatic test_hold();
    bit           to;
    logic [N-1:0] g;
    clear_obs();
    for (int i = 0; i < 9; i++) exp_q.push_back(N'(i));
    start_stream(14'd3, 4'd0, '0, '0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (got_q.size() >= 4) break;
    end
    // Beat 4 is on the output stage right now; pause over it.
    hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    hold = 1'b0;
    wait_done(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL hold_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() != 9) begin n_fail++; $display("FAIL hold_count: got %0d expected 9", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL hold_beat[%0d]: got %0h expected %0h", i, g, exp_q[i]); end
    end
    n_checks++; if (hold_beats != 0) begin n_fail++; $display("FAIL hold_beat_while_held: got %0d expected 0", hold_beats); end
    n_checks++; if (reads != 9) begin n_fail++; $display("FAIL hold_reads: got %0d expected 9", reads); end
  endtask

  task automatic test_zero_and_ignored();
    bit           to;
    logic [N-1:0] g;
    clear_obs();
    start_stream(14'd0, 4'd0, '0, '0);
    wait_done(50, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL zero_timeout: got no done expected done"); end
    n_checks++; if (reads != 0) begin n_fail++; $display("FAIL zero_reads: got %0d expected 0", reads); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL zero_beats: got %0d expected 0", got_q.size()); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d expected 1", dones); end

    clear_obs();
    for (int i = 0; i < 4; i++) exp_q.push_back(N'(i));
    start_stream(14'd2, 4'd0, '0, '0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignored_busy: got %b expected 1", busy); end
    msize = 14'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL ignored_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL ignored_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL ignored_beat[%0d]: got %0h expected %0h", i, g, exp_q[i]); end
    end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_reset_midstream();
    bit           to;
    logic [N-1:0] g;
    clear_obs();
    start_stream(14'd3, 4'd0, '0, '0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (got_q.size() >= 5) break;
    end
    rst = 1'b1;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (mem.mem_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_en: got %b expected 0", mem.mem_rd_en_o); end
    n_checks++; if (data !== '0) begin n_fail++; $display("FAIL midrst_data: got %0h expected 0", data); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d expected IDLE", dbg_state); end
    @(posedge clk); #1;
    rst = 1'b0;

    clear_obs();
    for (int i = 0; i < 9; i++) exp_q.push_back(N'(i));
    start_stream(14'd3, 4'd0, '0, '0);
    wait_done(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL restart_timeout: got no done expected done"); end
    n_checks++; if (got_q.size() != 9) begin n_fail++; $display("FAIL restart_count: got %0d expected 9", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL restart_beat[%0d]: got %0h expected %0h", i, g, exp_q[i]); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_base_offset();
`ifdef STREAMER_PADDING_EN
    test_padding();
`else
    test_no_padding();
`endif
    test_hold();
    test_zero_and_ignored();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
